sw_stripe_ctrl: RTL

//  Sequencer for a linear systolic array of N_PE affine-gap PE cells (one query base per PE).

---
 rtl/sw_stripe_ctrl_if.sv | 42 ++++
 rtl/sw_stripe_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sw_stripe_ctrl_if.sv
// Command/status bundle between a host and the systolic-array stripe sequencer.
// The host drives the i_* fields; the sequencer drives the o_* fields.
interface sw_stripe_ctrl_if #(
    parameter int N_PE  = 16,
    parameter int LEN_W = 10
) ();
    localparam int PE_W = (N_PE > 1) ? $clog2(N_PE) : 1;

    logic             i_start;
    logic [LEN_W-1:0] i_q_len;
    logic [LEN_W-1:0] i_r_len;
    logic             i_stall;

    logic             o_busy;
    logic             o_done;
    logic             o_q_load;
    logic [LEN_W-1:0] o_q_addr;
    logic [PE_W-1:0]  o_q_pe;
    logic             o_ref_valid;
    logic [LEN_W-1:0] o_ref_addr;
    logic             o_shift_en;
    logic [N_PE-1:0]  o_pe_valid;
    logic             o_first_stripe;
    logic             o_bnd_rd;
    logic [LEN_W-1:0] o_bnd_rd_addr;
    logic             o_bnd_wr;
    logic [LEN_W-1:0] o_bnd_wr_addr;

    modport master (
        output i_start, i_q_len, i_r_len, i_stall,
        input  o_busy, o_done, o_q_load, o_q_addr, o_q_pe, o_ref_valid, o_ref_addr,
               o_shift_en, o_pe_valid, o_first_stripe, o_bnd_rd, o_bnd_rd_addr,
               o_bnd_wr, o_bnd_wr_addr
    );

    modport slave (
        input  i_start, i_q_len, i_r_len, i_stall,
        output o_busy, o_done, o_q_load, o_q_addr, o_q_pe, o_ref_valid, o_ref_addr,
               o_shift_en, o_pe_valid, o_first_stripe, o_bnd_rd, o_bnd_rd_addr,
               o_bnd_wr, o_bnd_wr_addr
    );
endinterface

// File: rtl/sw_stripe_ctrl.sv
// Stripe sequencer for a linear affine-gap systolic array: loads N_PE query bases per stripe,
// streams the reference through the array and steers the inter-stripe boundary buffer.
module sw_stripe_ctrl #(
    parameter int N_PE  = 16,
    parameter int LEN_W = 10
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    sw_stripe_ctrl_if.slave bus
);
    localparam int CW   = LEN_W + 1;
    localparam int PE_W = (N_PE > 1) ? $clog2(N_PE) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] base_reg, base_next;
    logic [CW-1:0] q_len_reg, q_len_next;
    logic [CW-1:0] r_len_reg, r_len_next;

    logic          in_load, in_run, adv;
    logic          last_stripe;
    logic [CW-1:0] run_last;
    logic [N_PE-1:0] pe_valid;

    assign in_load     = (state_reg == LOAD);
    assign in_run      = (state_reg == RUN);
    assign adv         = (in_load || in_run) && !bus.i_stall;
    // Lengths are held one bit wider so base+N_PE and R+N_PE-1 never wrap.
    assign last_stripe = (base_reg + CW'(N_PE)) >= q_len_reg;
    assign run_last    = r_len_reg + CW'(N_PE - 2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            base_reg  <= '0;
            q_len_reg <= '0;
            r_len_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            base_reg  <= base_next;
            q_len_reg <= q_len_next;
            r_len_reg <= r_len_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        base_next  = base_reg;
        q_len_next = q_len_reg;
        r_len_next = r_len_reg;
        case (state_reg)
            IDLE: begin
                if (bus.i_start) begin
                    q_len_next = CW'(bus.i_q_len);
                    r_len_next = CW'(bus.i_r_len);
                    cnt_next   = '0;
                    base_next  = '0;
                    state_next = (bus.i_q_len == '0 || bus.i_r_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (adv) begin
                    if (cnt_reg == CW'(N_PE - 1)) begin
                        cnt_next   = '0;
                        state_next = RUN;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            RUN: begin
                if (adv) begin
                    if (cnt_reg == run_last) begin
                        cnt_next = '0;
                        if (last_stripe) begin
                            state_next = DONE;
                        end else begin
                            base_next  = base_reg + CW'(N_PE);
                            state_next = LOAD;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
                base_next  = '0;
                q_len_next = '0;
                r_len_next = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    // Cell k holds query base base+k and sees reference column c-k, valid for R columns.
    for (genvar gi = 0; gi < N_PE; gi++) begin : g_pe_valid
        assign pe_valid[gi] = in_run
                           && (cnt_reg >= CW'(gi))
                           && (cnt_reg < (r_len_reg + CW'(gi)))
                           && ((base_reg + CW'(gi)) < q_len_reg);
    end

    assign bus.o_busy         = (state_reg != IDLE);
    assign bus.o_done         = (state_reg == DONE);
    assign bus.o_q_load       = in_load && !bus.i_stall && ((base_reg + cnt_reg) < q_len_reg);
    assign bus.o_q_addr       = in_load ? LEN_W'(base_reg + cnt_reg) : '0;
    assign bus.o_q_pe         = in_load ? cnt_reg[PE_W-1:0] : '0;
    assign bus.o_ref_valid    = adv && in_run && (cnt_reg < r_len_reg);
    assign bus.o_ref_addr     = in_run ? cnt_reg[LEN_W-1:0] : '0;
    assign bus.o_shift_en     = adv && in_run;
    assign bus.o_pe_valid     = pe_valid;
    assign bus.o_first_stripe = (in_load || in_run) && (base_reg == '0);
    assign bus.o_bnd_rd       = bus.o_ref_valid && (base_reg != '0);
    assign bus.o_bnd_rd_addr  = in_run ? cnt_reg[LEN_W-1:0] : '0;
    // Only a stripe with a successor writes; last-PE column c-(N_PE-1) is the one leaving the array.
    assign bus.o_bnd_wr       = adv && in_run && (cnt_reg >= CW'(N_PE - 1)) && !last_stripe;
    assign bus.o_bnd_wr_addr  = in_run ? LEN_W'(cnt_reg - CW'(N_PE - 1)) : '0;
endmodule
